// File: rtl/tanh_pwl_pipe.sv
// Three-stage pipelined 4-segment piecewise-linear tanh on a valid/ready stream.
// Optional sigmoid mode (mode_sig port) is enabled by defining TANH_PWL_SIGMOID_EN.
module tanh_pwl_pipe #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef TANH_PWL_SIGMOID_EN
    input  logic              mode_sig,
`endif
    output logic [CNT_W-1:0]  sat_cnt
);

    localparam logic [DATA_W-1:0] ONE_C     = DATA_W'(1'b1) << FRAC_W;
    localparam logic [DATA_W-1:0] HALF_C    = ONE_C >> 1;
    localparam logic [DATA_W-1:0] QUARTER_C = ONE_C >> 2;
    localparam logic [DATA_W-1:0] TWO_C     = ONE_C << 1;
    localparam logic [DATA_W-1:0] MAX_C     = ONE_C - DATA_W'(1'b1);
    localparam logic [DATA_W-1:0] MIN_NEG_C = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_MAX_C = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        REG_R0 = 2'd0,
        REG_R1 = 2'd1,
        REG_R2 = 2'd2,
        REG_R3 = 2'd3
    } region_e;

    function automatic region_e classify(input logic [DATA_W-1:0] a, input logic min_neg);
        region_e r;
        if (min_neg || (a >= TWO_C)) begin
            r = REG_R3;
        end else if (a >= ONE_C) begin
            r = REG_R2;
        end else if (a >= HALF_C) begin
            r = REG_R1;
        end else begin
            r = REG_R0;
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] seg_mag(input logic [DATA_W-1:0] a, input region_e r);
        logic [DATA_W-1:0] m;
        case (r)
            REG_R0:  m = a;
            REG_R1:  m = (a >> 1) + QUARTER_C;
            REG_R2:  m = (a >> 2) + HALF_C;
            REG_R3:  m = MAX_C;
            default: m = MAX_C;
        endcase
        if (m > MAX_C) begin
            m = MAX_C;
        end
        return m;
    endfunction

    // Stage registers
    logic              s1_valid_r, s1_sign_r, s1_mode_r;
    logic [DATA_W-1:0] s1_abs_r;
    region_e           s1_region_r;
    logic              s2_valid_r, s2_sign_r, s2_mode_r;
    logic [DATA_W-1:0] s2_mag_r;

    logic              s1_en_s, s2_en_s, s3_en_s, in_xfer_s, mode_s;
    logic [DATA_W-1:0] pre_s, abs_s, mag_s, tanh_s, tanh_sh_s, res_s;
    logic              sign_s;
    region_e           region_s;

    // A stage may load when it is empty or its contents leave in the same cycle
    assign s3_en_s   = !out_valid || out_ready;
    assign s2_en_s   = !s2_valid_r || s3_en_s;
    assign s1_en_s   = !s1_valid_r || s2_en_s;
    assign in_ready  = s1_en_s;
    assign in_xfer_s = in_valid && s1_en_s;

    // Front end: optional sigmoid pre-shift, sign/abs and region classification
    always_comb begin
`ifdef TANH_PWL_SIGMOID_EN
        mode_s = mode_sig;
        if (mode_sig) begin
            pre_s = $signed(in_data) >>> 1;
        end else begin
            pre_s = in_data;
        end
`else
        mode_s = 1'b0;
        pre_s  = in_data;
`endif
        sign_s = pre_s[DATA_W-1];
        if (sign_s) begin
            abs_s = ~pre_s + DATA_W'(1'b1);
        end else begin
            abs_s = pre_s;
        end
        region_s = classify(abs_s, pre_s == MIN_NEG_C);
    end

    // S2 segment evaluation
    always_comb begin
        mag_s = seg_mag(s1_abs_r, s1_region_r);
    end

    // S3 sign restore and optional sigmoid remap; shift is kept in its own step to stay arithmetic
    always_comb begin
        if (s2_sign_r) begin
            tanh_s = ~s2_mag_r + DATA_W'(1'b1);
        end else begin
            tanh_s = s2_mag_r;
        end
        tanh_sh_s = $signed(tanh_s) >>> 1;
        if (s2_mode_r) begin
            res_s = tanh_sh_s + HALF_C;
        end else begin
            res_s = tanh_s;
        end
    end

    // S1 register: sign, magnitude, region, mode
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_sign_r   <= 1'b0;
            s1_mode_r   <= 1'b0;
            s1_abs_r    <= '0;
            s1_region_r <= REG_R0;
        end else if (s1_en_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r   <= sign_s;
                s1_mode_r   <= mode_s;
                s1_abs_r    <= abs_s;
                s1_region_r <= region_s;
            end
        end
    end

    // S2 register: output magnitude
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_sign_r  <= 1'b0;
            s2_mode_r  <= 1'b0;
            s2_mag_r   <= '0;
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sign_r <= s1_sign_r;
                s2_mode_r <= s1_mode_r;
                s2_mag_r  <= mag_s;
            end
        end
    end

    // S3 register drives the output stream; held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s3_en_s) begin
            out_valid <= s2_valid_r;
            if (s2_valid_r) begin
                out_data <= res_s;
            end
        end
    end

    // Saturation counter, updated on the edge the sample enters S1; sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (in_xfer_s && (region_s == REG_R3) && (sat_cnt != CNT_MAX_C)) begin
            sat_cnt <= sat_cnt + CNT_W'(1'b1);
        end
    end

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
// Self-checking bench for tanh_pwl_pipe: vector table stream plus backpressure, reset and counter sequences.
module tb_tanh_pwl_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic [15:0] sat_cnt;

    logic [7:0] c_in_data;
    logic       c_in_valid, c_in_ready;
    logic [7:0] c_out_data;
    logic       c_out_valid;
    logic [1:0] c_sat_cnt;
`ifdef TANH_PWL_SIGMOID_EN
    logic       mode_sig;
    logic       c_mode_sig;
`endif

    tanh_pwl_pipe #(.DATA_W(8), .FRAC_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef TANH_PWL_SIGMOID_EN
        .mode_sig(mode_sig),
`endif
        .sat_cnt(sat_cnt)
    );

    tanh_pwl_pipe #(.DATA_W(8), .FRAC_W(4), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst),
        .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(1'b1),
`ifdef TANH_PWL_SIGMOID_EN
        .mode_sig(c_mode_sig),
`endif
        .sat_cnt(c_sat_cnt)
    );

    typedef struct {
        logic [7:0] din;
        logic       mode;
        logic [7:0] dout;
        logic       sat;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] din, input logic mode, input logic [7:0] dout, input logic sat);
        vec_t v;
        v.din = din; v.mode = mode; v.dout = dout; v.sat = sat;
        vecs.push_back(v);
    endtask

    task automatic set_mode(input logic m);
`ifdef TANH_PWL_SIGMOID_EN
        mode_sig = m;
`else
        if (m) begin
            $display("FAIL set_mode: got 0x1 expected 0x0");
        end
`endif
    endtask

    // Back-to-back stream of the whole table with out_ready=1
    task automatic run_table();
        int exp_sat;
        int n;
        n = vecs.size();
        exp_sat = int'(sat_cnt);
        for (int k = 0; k <= n + 1; k++) begin
            if (k < n) begin
                in_data  = vecs[k].din;
                set_mode(vecs[k].mode);
                in_valid = 1'b1;
                check($sformatf("in_ready_v%0d", k), 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (k < n) begin
                exp_sat += int'(vecs[k].sat);
                check($sformatf("sat_cnt_v%0d", k), 32'(sat_cnt), 32'(exp_sat));
            end
            if (k >= 2) begin
                check($sformatf("out_valid_v%0d", k - 2), 32'(out_valid), 32'd1);
                check($sformatf("out_data_v%0d_in%02h", k - 2, vecs[k-2].din), 32'(out_data), 32'(vecs[k-2].dout));
            end
        end
        @(posedge clk); #1;
        check("table_drained", 32'(out_valid), 32'd0);
        set_mode(1'b0);
    endtask

    // Continuous stream 0x01..0x08 with downstream stalled for six cycles
    task automatic run_backpressure();
        int   sent = 0;
        int   got = 0;
        int   hold_bad = 0;
        logic saw_full = 1'b0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            out_ready = !(c >= 3 && c <= 8);
            in_valid  = (sent < 8);
            in_data   = 8'(sent + 1);
            #1;
            if (!out_ready && out_valid && out_data !== 8'h01) hold_bad++;
            if (!out_ready && !in_ready) saw_full = 1'b1;
            if (c == 5) check("bp_stall_valid", 32'(out_valid), 32'd1);
            if (out_valid && out_ready) begin
                check($sformatf("bp_order%0d", got), 32'(out_data), 32'(got + 1));
                got++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 32'(got), 32'd8);
        check("bp_in_ready_fell", 32'(saw_full), 32'd1);
        check("bp_hold_stable", 32'(hold_bad), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("bp_no_dup", 32'(out_valid), 32'd0);
    endtask

    // Reset while two samples are in flight, then a fresh sample
    task automatic run_reset_midflight();
        int stale = 0;
        int lat;
        in_data = 8'h10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h14;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_sat_cnt", 32'(sat_cnt), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        check("rst_mid_no_stale", 32'(stale), 32'd0);
        in_data = 8'h04; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rst_mid_latency", 32'(lat), 32'd3);
        check("rst_mid_data", 32'(out_data), 32'h04);
    endtask

    // Counter saturation on the CNT_W=2 instance
    task automatic run_cnt_sat();
        for (int i = 0; i < 5; i++) begin
            c_in_data = 8'h7F; c_in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("cnt_sat%0d", i), 32'(c_sat_cnt), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
        end
        c_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1;
        c_in_data = 8'h00; c_in_valid = 1'b0;
`ifdef TANH_PWL_SIGMOID_EN
        mode_sig = 1'b0; c_mode_sig = 1'b0;
`endif
        // din, mode, expected dout, counts as saturated
        add(8'h04, 1'b0, 8'h04, 1'b0);
        add(8'h0C, 1'b0, 8'h0A, 1'b0);
        add(8'h18, 1'b0, 8'h0E, 1'b0);
        add(8'h20, 1'b0, 8'h0F, 1'b1);
        add(8'hF4, 1'b0, 8'hF6, 1'b0);
        add(8'h80, 1'b0, 8'hF1, 1'b1);
        add(8'h00, 1'b0, 8'h00, 1'b0);
        add(8'h07, 1'b0, 8'h07, 1'b0);
        add(8'h08, 1'b0, 8'h08, 1'b0);
        add(8'h10, 1'b0, 8'h0C, 1'b0);
        add(8'h1F, 1'b0, 8'h0F, 1'b0);
        add(8'h7F, 1'b0, 8'h0F, 1'b1);
        add(8'h81, 1'b0, 8'hF1, 1'b1);
        add(8'hF0, 1'b0, 8'hF4, 1'b0);
        add(8'hFF, 1'b0, 8'hFF, 1'b0);
        add(8'hE0, 1'b0, 8'hF1, 1'b1);
`ifdef TANH_PWL_SIGMOID_EN
        add(8'h00, 1'b1, 8'h08, 1'b0);
        add(8'h40, 1'b1, 8'h0F, 1'b1);
        add(8'h0C, 1'b0, 8'h0A, 1'b0);
        add(8'hC0, 1'b1, 8'h00, 1'b1);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'h00);
        check("reset_sat_cnt", 32'(sat_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        run_table();
        run_backpressure();
        run_reset_midflight();
        run_cnt_sat();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
